// File: rtl/keypad_scan_if.sv
// keypad_scan_if: groups the keypad matrix lines and the decoded key outputs.
// The master side is the scanner itself; the slave side is the keypad plus
// whatever consumes the one-hot key code.
interface keypad_scan_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] onehot;
    logic        key_valid;

    modport master (
        input  row,
        output col,
        output onehot,
        output key_valid
    );

    modport slave (
        output row,
        input  col,
        input  onehot,
        input  key_valid
    );
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: scans a 4x4 active-low key matrix one column per slot,
// assembles a 16-bit pressed snapshot per frame and debounces it over
// DEBOUNCE identical frames. onehot only ever shows a single key; ambiguous
// multi-key snapshots are treated the same as "no key".
module keypad_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    keypad_scan_if.master bus
);
    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int STAB_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE);

    logic [3:0]        sync1_q, sync1_d;
    logic [3:0]        sync2_q, sync2_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        cidx_q, cidx_d;
    logic [3:0]        col_q, col_d;
    logic [15:0]       raw_q, raw_d;
    logic              frame_done_q, frame_done_d;
    logic [15:0]       last_cand_q, last_cand_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [15:0]       onehot_q, onehot_d;
    logic              key_valid_q, key_valid_d;

    logic              slot_end;
    logic [15:0]       cand;
    logic [STAB_W-1:0] stab_inc;

    // Next-state logic: scan timing, per-slot sampling and per-frame debounce
    always_comb begin
        sync1_d = bus.row;
        sync2_d = sync1_q;

        slot_end = (div_q == DIV_LAST);
        div_d    = slot_end ? '0 : div_q + 1'b1;
        cidx_d   = slot_end ? cidx_q + 2'd1 : cidx_q;
        col_d    = ~(4'b0001 << cidx_d);

        raw_d = raw_q;
        if (slot_end) begin
            raw_d[{cidx_q, 2'b00} +: 4] = ~sync2_q;
        end
        frame_done_d = slot_end && (cidx_q == 2'd3);

        cand     = ((raw_q != 16'h0000) && ((raw_q & (raw_q - 16'd1)) == 16'h0000)) ? raw_q : 16'h0000;
        stab_inc = (stab_q >= STAB_MAX) ? STAB_MAX : stab_q + 1'b1;

        last_cand_d = last_cand_q;
        stab_d      = stab_q;
        onehot_d    = onehot_q;
        key_valid_d = 1'b0;
        if (frame_done_q) begin
            if (cand == last_cand_q) begin
                stab_d = stab_inc;
            end else begin
                last_cand_d = cand;
                stab_d      = STAB_W'(1);
            end
            if ((stab_d == STAB_MAX) && (cand != onehot_q)) begin
                onehot_d    = cand;
                key_valid_d = (cand != 16'h0000);
            end
        end
    end

    // State registers; reset discards any partial frame or debounce progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 4'b1111;
            sync2_q      <= 4'b1111;
            div_q        <= '0;
            cidx_q       <= 2'd0;
            col_q        <= 4'b1110;
            raw_q        <= 16'h0000;
            frame_done_q <= 1'b0;
            last_cand_q  <= 16'h0000;
            stab_q       <= '0;
            onehot_q     <= 16'h0000;
            key_valid_q  <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            div_q        <= div_d;
            cidx_q       <= cidx_d;
            col_q        <= col_d;
            raw_q        <= raw_d;
            frame_done_q <= frame_done_d;
            last_cand_q  <= last_cand_d;
            stab_q       <= stab_d;
            onehot_q     <= onehot_d;
            key_valid_q  <= key_valid_d;
        end
    end

    assign bus.col       = col_q;
    assign bus.onehot    = onehot_q;
    assign bus.key_valid = key_valid_q;
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: drives a behavioural 4x4 keypad one frame at a time, queues
// the expected debounced result per frame and compares it when the frame's
// evaluation becomes visible on the outputs.
module tb_keypad_scan;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    typedef struct packed {
        logic [15:0] onehot;
        logic        valid;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keys  = 16'h0000;
    logic [3:0]  row_model;
    logic [3:0]  ecol;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    int pulses = 0;
    int base   = 0;

    exp_t expq[$];
    exp_t mon_e;

    logic [15:0] m_last;
    logic [15:0] m_onehot;
    int          m_stab;

    keypad_scan_if kif();

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kif)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low
    always_comb begin
        row_model = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!kif.col[c] && keys[c*4 + r]) row_model[r] = 1'b0;
            end
        end
    end
    assign kif.row = row_model;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, actual, expected, cyc);
    endtask

    // Cycles since reset release, used to locate slot and frame boundaries
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Output monitor: column walk every cycle, scoreboard pop at each evaluation, quiet key_valid elsewhere
    always @(negedge clk) begin
        if (rst_n) begin
            ecol = 4'b1111;
            ecol[(cyc / SCAN_DIV) % 4] = 1'b0;
            checkOutput("col", {12'h000, kif.col}, {12'h000, ecol});
            if (cyc >= FRAME + 1 && ((cyc - FRAME - 1) % FRAME) == 0) begin
                if (expq.size() > 0) begin
                    mon_e = expq.pop_front();
                    checkOutput("frame_onehot", kif.onehot, mon_e.onehot);
                    checkOutput("frame_valid", {15'h0000, kif.key_valid}, {15'h0000, mon_e.valid});
                end
            end else begin
                checkOutput("valid_idle", {15'h0000, kif.key_valid}, 16'h0000);
            end
            if (kif.key_valid === 1'b1) pulses++;
        end
    end

    // Drive one key pattern for a number of whole frames, queueing the expected result of each
    task automatic applyStimulus(input logic [15:0] k, input int nframes);
        logic [15:0] cand;
        exp_t        e;
        for (int f = 0; f < nframes; f++) begin
            keys = k;
            cand = ($countones(k) == 1) ? k : 16'h0000;
            if (cand == m_last) begin
                m_stab = (m_stab + 1 > DEBOUNCE) ? DEBOUNCE : m_stab + 1;
            end else begin
                m_last = cand;
                m_stab = 1;
            end
            e.valid = 1'b0;
            if (m_stab == DEBOUNCE && cand != m_onehot) begin
                m_onehot = cand;
                e.valid  = (cand != 16'h0000);
            end
            e.onehot = m_onehot;
            expq.push_back(e);
            repeat (FRAME) @(negedge clk);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        expq.delete();
        m_last   = 16'h0000;
        m_onehot = 16'h0000;
        m_stab   = 0;
        repeat (3) @(negedge clk);
        checkOutput("rst_col", {12'h000, kif.col}, 16'h000E);
        checkOutput("rst_onehot", kif.onehot, 16'h0000);
        checkOutput("rst_valid", {15'h0000, kif.key_valid}, 16'h0000);
        rst_n = 1'b1;
        base  = pulses;
    endtask

    task automatic checkScenario(input string tag, input logic [15:0] exp_onehot, input int exp_pulses);
        checkOutput({tag, "_onehot"}, kif.onehot, exp_onehot);
        checkOutput({tag, "_pulses"}, 16'(pulses - base), 16'(exp_pulses));
        base = pulses;
    endtask

    // Scenario sequence
    initial begin
        @(negedge clk);
        doReset();

        applyStimulus(16'h0200, 5);
        checkScenario("press", 16'h0200, 1);

        applyStimulus(16'h0040, 4);
        checkScenario("rollover", 16'h0040, 1);

        applyStimulus(16'h0000, 4);
        checkScenario("release", 16'h0000, 0);

        for (int i = 0; i < 8; i++) applyStimulus((i % 2 == 0) ? 16'h0200 : 16'h0000, 1);
        checkScenario("bounce", 16'h0000, 0);

        applyStimulus(16'h8001, 4);
        checkScenario("multi", 16'h0000, 0);

        applyStimulus(16'h0001, 4);
        checkScenario("multi_drop", 16'h0001, 1);

        applyStimulus(16'h0000, 4);
        checkScenario("release2", 16'h0000, 0);

        applyStimulus(16'h0200, 2);
        repeat (5) @(negedge clk);
        doReset();
        applyStimulus(16'h0200, 3);
        checkScenario("rst_early", 16'h0000, 0);
        applyStimulus(16'h0200, 1);
        checkScenario("rst_press", 16'h0200, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 active-low matrix keypad, debounces it, and emits a one-hot 16-bit key code. It feeds the one-hot-to-digit encoder that assembles entered digits for the display path. The block holds `onehot` stable while exactly one key is held and returns it to zero on release or on an ambiguous multi-key press. Scanning never stalls.

## Interface
- `SCAN_DIV`, 50000: clock cycles per column slot; must be ≥ 4.
- `DEBOUNCE`, 5: consecutive identical frames required before `onehot` changes; must be ≥ 1.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `row` in 4: keypad rows, active-low (pulled up externally), asynchronous to `clk`.
- `col` out 4: column drive, active-low, exactly one bit low at all times.
- `onehot` out 16: debounced key, bit index = col_idx*4 + row_idx; 16'h0000 = no key.
- `key_valid` out 1: one-cycle pulse when `onehot` takes a new non-zero value.

## Operation
- `row` passes through a 2-flop synchronizer. The pressed vector is `~row_sync`.
- Slot counter `div` runs 0..SCAN_DIV-1 and wraps. Column index `cidx` runs 0..3, increments when `div` wraps, and wraps 3→0.
- `col = ~(4'b0001 << cidx)` is registered, so it changes on the cycle after `div` wraps.
- Sample point: when `div == SCAN_DIV-1`, the block writes `raw[cidx*4 +: 4] <= ~row_sync`.
- Frame: 4 slots = 4*SCAN_DIV cycles. `frame_done` is a registered pulse on the cycle after the col-3 sample.
- Evaluation, one cycle, on `frame_done`:
  - `cand = raw` if `raw` has exactly one bit set, else 16'h0000. This covers 0 or ≥2 bits set.
  - If `cand == last_cand`, then `stab <= min(stab+1, DEBOUNCE)`. Otherwise `last_cand <= cand` and `stab <= 1`.
  - When the new `stab` value equals `DEBOUNCE` and `cand != onehot`, then `onehot <= cand`.
  - `key_valid <= 1` in that same update only if `cand != 0`. Otherwise `key_valid <= 0`.
- Debounce behaviour, expressed as states: IDLE (`onehot=0`) → PEND (candidate differs, `stab<DEBOUNCE`) → HELD (`onehot=cand`). While HELD, any differing candidate re-enters PEND. A stable zero candidate returns the block to IDLE with no pulse.
- A key held indefinitely produces exactly one `key_valid` pulse.
- A change directly from key A to key B, with no released frame in between, produces a pulse for B.
- `raw` slots are overwritten every frame. Stale data never survives beyond one frame.
- Counter widths:
  - `div`: $clog2(SCAN_DIV).
  - `stab`: $clog2(DEBOUNCE+1), saturating.
  - `cidx`: 2 bits, natural wrap.

## Timing
- Reset values: `col=4'b1110`, `onehot=16'h0000`, `key_valid=0`, `div=0`, `cidx=0`, `raw=0`, `last_cand=0`, `stab=0`, synchronizer flops = 4'b1111.
- Reset mid-debounce or mid-frame discards all partial state. The first full frame after release starts at `div=0, cidx=0`.
- Row-to-sample latency is 2 cycles through the synchronizer. Row settles after a column change within SCAN_DIV-3 cycles.
- Press latency: a key stable from the start of frame N updates `onehot` in the cycle after the evaluation of frame N+DEBOUNCE-1, i.e. `onehot` updates 1 cycle after that frame's `frame_done`.
- `key_valid` and the `onehot` change are visible in the same cycle. `key_valid` is high for exactly 1 cycle.
- Release latency equals press latency. `key_valid` stays 0 on release.
- With `DEBOUNCE=1`, `onehot` follows each frame's candidate.

## Test plan
All scenarios use `SCAN_DIV=4`, `DEBOUNCE=3`, so frame = 16 cycles.
- Reset: hold `rst_n=0`, then release → `col=1110`, `onehot=0`, `key_valid=0`. `col` then cycles 1101, 1011, 0111, 1110 every 4 cycles.
- Single press: model pulls `row[1]` low whenever `col=1011`, held for 5 frames → `onehot=16'h0200` after frame 3 evaluation, one `key_valid` pulse, no further pulses.
- Bounce: the same key is present in alternating frames for 8 frames → `onehot` stays 0, `key_valid` is never asserted.
- Multi-key: row0 with col0 and row3 with col3 pressed together for 4 frames → `onehot` stays 16'h0000 and there is no pulse. Releasing col3 afterwards → `onehot=16'h0001` after 3 frames, with a pulse.
- Release/rollover: from HELD at 16'h0200, switch directly to row2/col1 → `onehot=16'h0040` with a pulse after 3 frames. Releasing → `onehot=0` after 3 frames, no pulse.
- Reset mid-debounce: assert `rst_n=0` after 2 stable frames of a press, then release it with the key still held → `onehot` updates only after 3 new full frames.
